pulse_width_meter: RTL and testbench

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

---
 rtl/pulse_width_meter.sv | 109 ++++++++++
 tb/tb_pulse_width_meter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// Pulse width meter: times the high phase of an asynchronous input
// in millisecond ticks and latches the result on the falling edge.
module pulse_width_meter #(
  parameter int TICK_DIV  = 50_000,
  parameter int MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_in,
  output logic [14:0] cont_tiempo,
  output logic        medicion_lista,
  output logic        midiendo,
  output logic        desborde
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [14:0] CNT_MAX = 15'(MAX_COUNT);

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    MEASURE
  } state_t;

  state_t      state;
  logic        sync1;
  logic        synced;
  logic        prev;
  logic [1:0]  fill;
  logic [PW-1:0] presc;
  logic [14:0] ms_cnt;
  logic        ovf;

  logic        rise;
  logic        fall;
  logic        tick;
  logic        at_max;
  logic [14:0] cnt_nxt;
  logic        ovf_nxt;

  assign rise    = synced & ~prev;
  assign fall    = ~synced & prev;
  assign tick    = (presc == TICK_LAST);
  assign at_max  = (ms_cnt == CNT_MAX);
  assign cnt_nxt = (tick && !at_max) ? ms_cnt + 15'd1 : ms_cnt;
  assign ovf_nxt = ovf | (tick & at_max);

  // fill counts edges since reset so the exit from WAIT_LOW only
  // trusts a synchronized sample of the real input, not reset zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
      fill   <= 2'd0;
    end else begin
      sync1  <= pulse_in;
      synced <= sync1;
      prev   <= synced;
      if (fill != 2'd2)
        fill <= fill + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_LOW;
      presc          <= '0;
      ms_cnt         <= '0;
      ovf            <= 1'b0;
      cont_tiempo    <= '0;
      medicion_lista <= 1'b0;
      midiendo       <= 1'b0;
      desborde       <= 1'b0;
    end else begin
      medicion_lista <= 1'b0;
      unique case (state)
        WAIT_LOW: begin
          if (fill == 2'd2 && !synced)
            state <= IDLE;
        end
        IDLE: begin
          if (rise) begin
            state    <= MEASURE;
            midiendo <= 1'b1;
            presc    <= '0;
            ms_cnt   <= '0;
            ovf      <= 1'b0;
          end
        end
        MEASURE: begin
          presc  <= tick ? '0 : presc + 1'b1;
          ms_cnt <= cnt_nxt;
          ovf    <= ovf_nxt;
          if (fall) begin
            state          <= IDLE;
            midiendo       <= 1'b0;
            cont_tiempo    <= cnt_nxt;
            desborde       <= ovf_nxt;
            medicion_lista <= 1'b1;
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: directed scenarios plus random pulse
// trains checked against width/TICK_DIV arithmetic.
module tb_pulse_width_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b0;
  logic pin_c = 1'b0;

  logic [14:0] cont_a, cont_b, cont_c;
  logic lista_a, lista_b, lista_c;
  logic mid_a, mid_b, mid_c;
  logic desb_a, desb_b, desb_c;

  int checks = 0;
  int errors = 0;
  int nstr_a = 0;
  int nstr_b = 0;
  int nstr_c = 0;
  int run_a = 0;
  int run_b = 0;
  int qa[$];
  int qb[$];

  always #10 clk = ~clk;

  pulse_width_meter #(.TICK_DIV(10), .MAX_COUNT(9999)) dut_a (
    .clk(clk), .rst(rst), .pulse_in(pin),
    .cont_tiempo(cont_a), .medicion_lista(lista_a),
    .midiendo(mid_a), .desborde(desb_a)
  );

  pulse_width_meter #(.TICK_DIV(10), .MAX_COUNT(5)) dut_b (
    .clk(clk), .rst(rst), .pulse_in(pin),
    .cont_tiempo(cont_b), .medicion_lista(lista_b),
    .midiendo(mid_b), .desborde(desb_b)
  );

  pulse_width_meter dut_c (
    .clk(clk), .rst(rst), .pulse_in(pin_c),
    .cont_tiempo(cont_c), .medicion_lista(lista_c),
    .midiendo(mid_c), .desborde(desb_c)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ms_of(input int n, input int mx);
    return (n / 10 > mx) ? mx : n / 10;
  endfunction

  // Every strobe must correspond to a pulse the driver queued.
  always @(negedge clk) begin
    int n;
    if (rst) run_a = 0;
    else if (mid_a) run_a++;
    if (rst) run_b = 0;
    else if (mid_b) run_b++;
    if (lista_a) begin
      nstr_a++;
      chk("a_stray", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        n = qa.pop_front();
        chk("a_cont", int'(cont_a), ms_of(n, 9999));
        chk("a_desb", int'(desb_a), 0);
        chk("a_run", run_a, n);
      end
      run_a = 0;
    end
    if (lista_b) begin
      nstr_b++;
      chk("b_stray", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        n = qb.pop_front();
        chk("b_cont", int'(cont_b), ms_of(n, 5));
        chk("b_desb", int'(desb_b), int'(n / 10 > 5));
        chk("b_run", run_b, n);
      end
      run_b = 0;
    end
    if (lista_c) nstr_c++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    qa.push_back(hi);
    qb.push_back(hi);
    pin = 1'b1;
    cyc(hi);
    pin = 1'b0;
    cyc(lo);
  endtask

  initial begin
    int s0;
    int hi;
    int lo;
    // input already high through reset: first pulse must be ignored
    pin = 1'b1;
    cyc(5);
    chk("rst_cont", int'(cont_a), 0);
    chk("rst_lista", int'(lista_a), 0);
    chk("rst_mid", int'(mid_a), 0);
    chk("rst_desb", int'(desb_a), 0);
    rst = 1'b0;
    cyc(10);
    chk("wl_mid", int'(mid_a), 0);
    cyc(20);
    pin = 1'b0;
    cyc(6);
    chk("wl_nostrobe", nstr_a, 0);
    pulse(25, 8);
    chk("wl_one", nstr_a, 1);
    chk("wl_cont", int'(cont_a), 2);

    // clean reset, 47-cycle pulse
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    pulse(47, 8);
    chk("p47_cont", int'(cont_a), 4);

    // glitch: old value held until its own strobe
    pin = 1'b1;
    cyc(5);
    pin = 1'b0;
    cyc(2);
    chk("gl_hold", int'(cont_a), 4);
    qa.push_back(5);
    qb.push_back(5);
    cyc(8);
    chk("gl_cont", int'(cont_a), 0);

    // saturation on the MAX_COUNT=5 instance, then recovery
    pulse(100, 8);
    chk("sat_b", int'(cont_b), 5);
    chk("sat_desb", int'(desb_b), 1);
    pulse(25, 8);
    chk("rec_desb", int'(desb_b), 0);

    // reset mid-pulse discards the measurement
    pulse(40, 8);
    s0 = nstr_a;
    pin = 1'b1;
    cyc(20);
    rst = 1'b1;
    cyc(1);
    chk("ab_cont", int'(cont_a), 0);
    chk("ab_mid", int'(mid_a), 0);
    chk("ab_desb", int'(desb_b), 0);
    rst = 1'b0;
    cyc(30);
    chk("ab_mid2", int'(mid_a), 0);
    pin = 1'b0;
    cyc(5);
    chk("ab_nostrobe", nstr_a, s0);
    pulse(12, 8);
    chk("ab_resume", int'(cont_a), 1);

    // random trains, including back-to-back pulses
    for (int i = 0; i < 40; i++) begin
      hi = $urandom_range(1, 130);
      lo = (i % 5 == 0) ? 1 : $urandom_range(1, 15);
      pulse(hi, lo);
    end
    cyc(10);
    chk("rnd_drain_a", qa.size(), 0);
    chk("rnd_drain_b", qb.size(), 0);
    chk("rnd_strobes", nstr_a, nstr_b);

    // default parameters, 1.5 ms
    pin_c = 1'b1;
    cyc(75000);
    pin_c = 1'b0;
    cyc(10);
    chk("def_strobes", nstr_c, 1);
    chk("def_cont", int'(cont_c), 1);
    chk("def_desb", int'(desb_c), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
